// File: rtl/video_timing_pkg.sv
// Shared types and default raster timing for the video timing generator.
package video_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } axis_state_t;

  // Width of the x/y coordinates; each axis total must fit in this many bits.
  localparam int COORD_W = 9;

  localparam int DEF_H_ACTIVE = 320;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_H_SYNC   = 32;
  localparam int DEF_H_BACK   = 80;

  localparam int DEF_V_ACTIVE = 256;
  localparam int DEF_V_FRONT  = 8;
  localparam int DEF_V_SYNC   = 4;
  localparam int DEF_V_BACK   = 44;

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: a wrapping counter plus the ACTIVE/FRONT/SYNC/BACK region FSM.
// count and state present the values that will hold after the current edge,
// so the parent can register its flags in lockstep with the coordinates.
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FRONT_LEN  = DEF_H_FRONT,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter int BACK_LEN   = DEF_H_BACK
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               advance,
  output logic [COORD_W-1:0] count,
  output axis_state_t        state,
  output logic               wrap
);

  localparam int TOTAL = ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN;

  localparam logic [COORD_W-1:0] ACTIVE_END = COORD_W'(ACTIVE_LEN - 1);
  localparam logic [COORD_W-1:0] FRONT_END  = COORD_W'(ACTIVE_LEN + FRONT_LEN - 1);
  localparam logic [COORD_W-1:0] SYNC_END   = COORD_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN - 1);
  localparam logic [COORD_W-1:0] LAST       = COORD_W'(TOTAL - 1);

  // Region ends are exact-match compares, so every region needs at least one
  // cycle and the whole line/frame must fit the coordinate width.
  if ((TOTAL > (1 << COORD_W)) || (ACTIVE_LEN < 1) || (FRONT_LEN < 1) ||
      (SYNC_LEN < 1) || (BACK_LEN < 1)) begin : g_bad_params
    $fatal(1, "timing_axis: region lengths must be >= 1 and total <= 512");
  end

  logic [COORD_W-1:0] count_q, count_d;
  axis_state_t        state_q, state_d;

  // Counter and region FSM next-state; a region ends when the counter sits on its last value.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    wrap    = 1'b0;
    if (advance) begin
      if (count_q == LAST) begin
        count_d = '0;
        wrap    = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
      case (state_q)
        ACTIVE:  if (count_q == ACTIVE_END) state_d = FRONT;
        FRONT:   if (count_q == FRONT_END)  state_d = SYNC;
        SYNC:    if (count_q == SYNC_END)   state_d = BACK;
        BACK:    if (count_q == LAST)       state_d = ACTIVE;
        default: state_d = ACTIVE;
      endcase
    end
  end

  // Axis state register, cleared to the start of the ACTIVE region.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      state_q <= ACTIVE;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign count = count_d;
  assign state = state_d;

endmodule

// File: rtl/video_timing.sv
// Raster scan generator: x/y coordinates with sync, active and start markers,
// all registered together so flags always describe the presented coordinate.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  output logic [COORD_W-1:0] video_x,
  output logic [COORD_W-1:0] video_y,
  output logic               active_,
  output logic               hsync_,
  output logic               vsync_,
  output logic               line_start_,
  output logic               frame_start_
);

  logic [COORD_W-1:0] h_count, v_count;
  axis_state_t        h_state, v_state;
  logic               h_wrap, v_wrap;

  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic active_q, active_d, hsync_q, hsync_d, vsync_q, vsync_d;
  logic line_start_q, line_start_d, frame_start_q, frame_start_d;

  timing_axis #(
    .ACTIVE_LEN(H_ACTIVE), .FRONT_LEN(H_FRONT), .SYNC_LEN(H_SYNC), .BACK_LEN(H_BACK)
  ) u_h_axis (
    .clock   (clock),
    .reset   (reset),
    .advance (enable),
    .count   (h_count),
    .state   (h_state),
    .wrap    (h_wrap)
  );

  timing_axis #(
    .ACTIVE_LEN(V_ACTIVE), .FRONT_LEN(V_FRONT), .SYNC_LEN(V_SYNC), .BACK_LEN(V_BACK)
  ) u_v_axis (
    .clock   (clock),
    .reset   (reset),
    .advance (enable & h_wrap),
    .count   (v_count),
    .state   (v_state),
    .wrap    (v_wrap)
  );

  // Flags from the post-edge axis values; a wrap on an enabled edge means x (and y) land on 0.
  always_comb begin
    x_d           = x_q;
    y_d           = y_q;
    active_d      = active_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    line_start_d  = line_start_q;
    frame_start_d = frame_start_q;
    if (enable) begin
      x_d           = h_count;
      y_d           = v_count;
      active_d      = (h_state == ACTIVE) && (v_state == ACTIVE);
      hsync_d       = (h_state == SYNC);
      vsync_d       = (v_state == SYNC);
      line_start_d  = h_wrap;
      frame_start_d = v_wrap;
    end
  end

  // Output registers; reset presents pixel (0,0) at the start of a frame.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x_q           <= '0;
      y_q           <= '0;
      active_q      <= 1'b1;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      line_start_q  <= 1'b1;
      frame_start_q <= 1'b1;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      active_q      <= active_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign video_x      = x_q;
  assign video_y      = y_q;
  assign active_      = active_q;
  assign hsync_       = hsync_q;
  assign vsync_       = vsync_q;
  assign line_start_  = line_start_q;
  assign frame_start_ = frame_start_q;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: a default-sized instance for the horizontal boundary
// points and a tiny-raster instance (single-cycle H sync and V front porch)
// that can be run through whole frames; both are tracked by a coordinate model.
module tb_video_timing;

  localparam int S_HA = 8, S_HF = 2, S_HS = 1, S_HB = 3;
  localparam int S_VA = 5, S_VF = 1, S_VS = 2, S_VB = 1;
  localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
  localparam int S_VT = S_VA + S_VF + S_VS + S_VB;

  localparam int D_HA = 320, D_HF = 16, D_HS = 32, D_HB = 80;
  localparam int D_VA = 256, D_VF = 8, D_VS = 4, D_VB = 44;
  localparam int D_HT = D_HA + D_HF + D_HS + D_HB;
  localparam int D_VT = D_VA + D_VF + D_VS + D_VB;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic cmp_on = 1'b0;

  logic [8:0] s_x, s_y, d_x, d_y;
  logic s_active, s_hsync, s_vsync, s_ls, s_fs;
  logic d_active, d_hsync, d_vsync, d_ls, d_fs;

  int n_checks = 0;
  int n_fail = 0;

  int sx = 0, sy = 0, dx = 0, dy = 0;

  always #5 clock = ~clock;

  video_timing #(
    .H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
    .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB)
  ) dut_small (
    .clock(clock), .reset(reset), .enable(enable),
    .video_x(s_x), .video_y(s_y),
    .active_(s_active), .hsync_(s_hsync), .vsync_(s_vsync),
    .line_start_(s_ls), .frame_start_(s_fs)
  );

  video_timing dut_def (
    .clock(clock), .reset(reset), .enable(enable),
    .video_x(d_x), .video_y(d_y),
    .active_(d_active), .hsync_(d_hsync), .vsync_(d_vsync),
    .line_start_(d_ls), .frame_start_(d_fs)
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, actual, expected, $time);
    end
  endtask

  // Expected outputs follow directly from the model coordinate and the region sizes.
  task automatic checkModel(input string tag, input int x, input int y,
                            input logic act, input logic hs, input logic vs,
                            input logic ls, input logic fs,
                            input int mx, input int my,
                            input int ha, input int hf, input int hsl,
                            input int va, input int vf, input int vsl);
    checkOutput({tag, ".x"}, x, mx);
    checkOutput({tag, ".y"}, y, my);
    checkOutput({tag, ".active"}, int'(act), int'(mx < ha && my < va));
    checkOutput({tag, ".hsync"}, int'(hs), int'(mx >= ha + hf && mx < ha + hf + hsl));
    checkOutput({tag, ".vsync"}, int'(vs), int'(my >= va + vf && my < va + vf + vsl));
    checkOutput({tag, ".line_start"}, int'(ls), int'(mx == 0));
    checkOutput({tag, ".frame_start"}, int'(fs), int'(mx == 0 && my == 0));
  endtask

  // Reference raster position: steps on every enabled edge, zeroed by reset.
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sx = 0; sy = 0; dx = 0; dy = 0;
    end else if (enable) begin
      sx = (sx + 1) % S_HT;
      if (sx == 0) sy = (sy + 1) % S_VT;
      dx = (dx + 1) % D_HT;
      if (dx == 0) dy = (dy + 1) % D_VT;
    end
  end

  // Every cycle, a little after the edge, both instances must match the model.
  always @(posedge clock) begin
    #3;
    if (cmp_on) begin
      checkModel("small", int'(s_x), int'(s_y), s_active, s_hsync, s_vsync, s_ls, s_fs,
                 sx, sy, S_HA, S_HF, S_HS, S_VA, S_VF, S_VS);
      checkModel("def", int'(d_x), int'(d_y), d_active, d_hsync, d_vsync, d_ls, d_fs,
                 dx, dy, D_HA, D_HF, D_HS, D_VA, D_VF, D_VS);
    end
  end

  // Drives n clock edges with enable high on every duty-th edge, then returns
  // 3 time units after the last of those edges.
  task automatic applyStimulus(input int n, input int duty);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      enable = ((i % duty) == 0);
    end
    @(posedge clock);
    #3;
  endtask

  task automatic pulseReset();
    @(negedge clock);
    reset = 1'b1;
    enable = 1'b0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".s_x"}, int'(s_x), 0);
    checkOutput({tag, ".s_y"}, int'(s_y), 0);
    checkOutput({tag, ".s_active"}, int'(s_active), 1);
    checkOutput({tag, ".s_hsync"}, int'(s_hsync), 0);
    checkOutput({tag, ".s_vsync"}, int'(s_vsync), 0);
    checkOutput({tag, ".s_line_start"}, int'(s_ls), 1);
    checkOutput({tag, ".s_frame_start"}, int'(s_fs), 1);
    checkOutput({tag, ".d_x"}, int'(d_x), 0);
    checkOutput({tag, ".d_y"}, int'(d_y), 0);
    checkOutput({tag, ".d_frame_start"}, int'(d_fs), 1);
  endtask

  initial begin
    #1;
    reset = 1'b1;
    enable = 1'b0;
    cmp_on = 1'b1;

    @(negedge clock);
    checkResetValues("reset");

    // First enabled edge after release presents x = 1
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(1, 1);
    checkOutput("first.d_x", int'(d_x), 1);
    checkOutput("first.d_y", int'(d_y), 0);
    checkOutput("first.d_active", int'(d_active), 1);
    checkOutput("first.d_hsync", int'(d_hsync), 0);
    checkOutput("first.d_line_start", int'(d_ls), 0);

    @(negedge clock);
    reset = 1'b1;
    enable = 1'b0;
    #1;
    checkResetValues("rereset");
    @(negedge clock);
    reset = 1'b0;

    // Horizontal boundaries on the default instance
    applyStimulus(319, 1);
    checkOutput("h319.x", int'(d_x), 319);
    checkOutput("h319.active", int'(d_active), 1);
    applyStimulus(1, 1);
    checkOutput("h320.x", int'(d_x), 320);
    checkOutput("h320.active", int'(d_active), 0);
    applyStimulus(15, 1);
    checkOutput("h335.hsync", int'(d_hsync), 0);
    applyStimulus(1, 1);
    checkOutput("h336.x", int'(d_x), 336);
    checkOutput("h336.hsync", int'(d_hsync), 1);
    applyStimulus(31, 1);
    checkOutput("h367.hsync", int'(d_hsync), 1);
    applyStimulus(1, 1);
    checkOutput("h368.hsync", int'(d_hsync), 0);
    applyStimulus(79, 1);
    checkOutput("h447.x", int'(d_x), 447);
    checkOutput("h447.y", int'(d_y), 0);
    applyStimulus(1, 1);
    checkOutput("hwrap.x", int'(d_x), 0);
    checkOutput("hwrap.y", int'(d_y), 1);
    checkOutput("hwrap.line_start", int'(d_ls), 1);
    checkOutput("hwrap.frame_start", int'(d_fs), 0);

    // 448 edges = 32 small lines: small raster sits at (0,5)
    checkOutput("small.y5", int'(s_y), 5);
    applyStimulus(14, 1);
    checkOutput("small.y6.vsync", int'(s_vsync), 1);
    applyStimulus(27, 1);
    checkOutput("small.13_7.x", int'(s_x), 13);
    checkOutput("small.13_7.vsync", int'(s_vsync), 1);
    applyStimulus(1, 1);
    checkOutput("small.y8.vsync", int'(s_vsync), 0);
    applyStimulus(13, 1);
    checkOutput("small.last.x", int'(s_x), 13);
    checkOutput("small.last.y", int'(s_y), 8);
    applyStimulus(1, 1);
    checkOutput("small.fwrap.x", int'(s_x), 0);
    checkOutput("small.fwrap.y", int'(s_y), 0);
    checkOutput("small.fwrap.frame_start", int'(s_fs), 1);
    checkOutput("small.fwrap.active", int'(s_active), 1);

    // 1-in-3 enable: 30 edges advance 10 pixels onto the single-cycle hsync
    pulseReset();
    applyStimulus(30, 3);
    checkOutput("duty.x10", int'(s_x), 10);
    checkOutput("duty.x10.hsync", int'(s_hsync), 1);
    checkOutput("duty.x10.active", int'(s_active), 0);
    applyStimulus(3, 3);
    checkOutput("duty.x11", int'(s_x), 11);
    checkOutput("duty.x11.hsync", int'(s_hsync), 0);
    applyStimulus(400, 3);

    // Asynchronous reset mid-frame at (200,100) on the default instance
    pulseReset();
    applyStimulus(100 * D_HT + 200, 1);
    checkOutput("mid.x", int'(d_x), 200);
    checkOutput("mid.y", int'(d_y), 100);
    #4;
    reset = 1'b1;
    #1;
    checkResetValues("async");
    @(negedge clock);
    reset = 1'b0;
    enable = 1'b0;
    applyStimulus(5, 1);
    checkOutput("resume.x", int'(d_x), 5);
    checkOutput("resume.y", int'(d_y), 0);

    @(negedge clock);
    enable = 1'b0;
    cmp_on = 1'b0;
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Safety net in case the stimulus sequence never completes.
  initial begin
    #3000000;
    n_fail++;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
